// File: rtl/wb_trace_checker.sv
// wb_trace_checker: in-order checker of regfile write-backs against a loaded expected trace.
// Define TRACE_TIMEOUT_EN to add an idle-cycle watchdog that fails after TIMEOUT cycles in ARMED.
module wb_trace_checker #(
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int DEPTH     = 64,
    parameter int TIMEOUT   = 1024,
    parameter int IGNORE_R0 = 1,
    localparam int IW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_we,
    input  logic [IW-1:0] ld_idx,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    input  logic [LW-1:0] exp_len,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic          timeout,
    output logic [LW-1:0] match_cnt,
    output logic [LW-1:0] err_idx,
    output logic [AW-1:0] err_addr,
    output logic [DW-1:0] err_data
);
    if (DEPTH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("wb_trace_checker: DEPTH must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} state_t;

    state_t        r_state;
    logic [AW-1:0] r_mem_addr [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [LW-1:0] r_idx;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_err_idx;
    logic [AW-1:0] r_err_addr;
    logic [DW-1:0] r_err_data;
    logic          r_timeout;

    logic          w_qual;
    logic          w_miss;
    logic          w_tout;
    logic [LW-1:0] w_len;

    assign w_qual = wb_we && !(IGNORE_R0 != 0 && wb_waddr == '0);
    // Case-inequality so X/Z on the write-back port is always a mismatch.
    assign w_miss = (wb_waddr !== r_mem_addr[r_idx[IW-1:0]]) || (wb_wdata !== r_mem_data[r_idx[IW-1:0]]);
    assign w_len  = (exp_len > LW'(DEPTH)) ? LW'(DEPTH) : exp_len;

`ifdef TRACE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;
    assign w_tout = r_tcnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tcnt <= '0;
        else if (start || w_qual || r_state != ARMED)
            r_tcnt <= '0;
        else
            r_tcnt <= r_tcnt + 1'b1;
    end
`else
    assign w_tout = 1'b0;
`endif

    // Trace memory is deliberately not reset so a bench can reload only what changes.
    always_ff @(posedge clk) begin
        if (ld_we && r_state != ARMED) begin
            r_mem_addr[ld_idx] <= ld_addr;
            r_mem_data[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_len      <= '0;
            r_err_idx  <= '0;
            r_err_addr <= '0;
            r_err_data <= '0;
            r_timeout  <= 1'b0;
        end else if (start) begin
            r_state    <= (w_len == '0) ? PASS : ARMED;
            r_idx      <= '0;
            r_len      <= w_len;
            r_err_idx  <= '0;
            r_err_addr <= '0;
            r_err_data <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ARMED: begin
                    if (w_qual && w_miss) begin
                        r_state    <= FAIL;
                        r_err_idx  <= r_idx;
                        r_err_addr <= wb_waddr;
                        r_err_data <= wb_wdata;
                    end else if (w_qual) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == r_len - LW'(1))
                            r_state <= PASS;
                    end else if (w_tout) begin
                        r_state    <= FAIL;
                        r_timeout  <= 1'b1;
                        r_err_idx  <= r_idx;
                        r_err_addr <= '0;
                        r_err_data <= '0;
                    end
                end
                PASS: begin
                    if (w_qual) begin
                        r_state    <= FAIL;
                        r_err_idx  <= r_len;
                        r_err_addr <= wb_waddr;
                        r_err_data <= wb_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_state == ARMED;
    assign done      = r_state == PASS || r_state == FAIL;
    assign pass      = r_state == PASS;
    assign fail      = r_state == FAIL;
    assign timeout   = r_timeout;
    assign match_cnt = r_idx;
    assign err_idx   = r_err_idx;
    assign err_addr  = r_err_addr;
    assign err_data  = r_err_data;
endmodule
